// File: rtl/imm_encode_pkg.sv
// Shared immediate-encoding definitions: ImmSrc codes, FSM states and the
// rotation step count, common to the encoder and the datapath extender.
package imm_defs;

    localparam int ROT_STEPS_DEF = 16;

    typedef enum logic [1:0] {
        IMM_DP  = 2'b00,
        IMM_MEM = 2'b01,
        IMM_BR  = 2'b10,
        IMM_RSV = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEARCH = 2'b01,
        DONE   = 2'b10
    } enc_state_e;

    typedef struct packed {
        logic        encodable;
        logic [23:0] instr;
    } imm_fit_t;

    // Rotate left by two bit positions (one rotation step of the imm8 search).
    function automatic logic [31:0] rol2(input logic [31:0] v);
        return {v[29:0], v[31:30]};
    endfunction

endpackage

// File: rtl/imm_encode_if.sv
// Request/response handshake bundle for the immediate encoder.
interface imm_encode_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] value;
    logic [1:0]  ImmSrc;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] Instr;
    logic        encodable;

    modport master (
        output in_valid, value, ImmSrc, out_ready,
        input  in_ready, out_valid, Instr, encodable
    );

    modport slave (
        input  in_valid, value, ImmSrc, out_ready,
        output in_ready, out_valid, Instr, encodable
    );
endinterface

// File: rtl/imm_encode_fit_check.sv
// Combinational fit check for the non-rotating immediate forms; returns
// {encodable, Instr}. Mode 00 here is the plain zero-extended imm8 form.
module imm_fit_check
    import imm_defs::*;
(
    input  logic [31:0] value,
    input  logic [1:0]  imm_src,
    output imm_fit_t    fit
);

    // Select the field and its representability for each immediate form.
    always_comb begin
        fit = '0;
        case (imm_src_e'(imm_src))
            IMM_DP: begin
                if (value[31:8] == 24'h000000) begin
                    fit.encodable = 1'b1;
                    fit.instr     = {16'h0000, value[7:0]};
                end else begin
                    fit = '0;
                end
            end
            IMM_MEM: begin
                if (value[31:12] == 20'h00000) begin
                    fit.encodable = 1'b1;
                    fit.instr     = {12'h000, value[11:0]};
                end else begin
                    fit = '0;
                end
            end
            IMM_BR: begin
                // Branch offset must be word aligned and sign-extended from bit 25.
                if ((value[1:0] == 2'b00) && (value[31:25] == {7{value[25]}})) begin
                    fit.encodable = 1'b1;
                    fit.instr     = value[25:2];
                end else begin
                    fit = '0;
                end
            end
            default: fit = '0;
        endcase
    end

endmodule

// File: rtl/imm_encode.sv
// Immediate encoder: inverse of the datapath extender behind a valid/ready
// handshake. Define ROT_IMM_EN to enable the iterative imm8+rotate search.
module imm_encode
    import imm_defs::*;
`ifdef ROT_IMM_EN
#(
    parameter int ROT_STEPS = ROT_STEPS_DEF
)
`endif
(
    input  logic        clk,
    input  logic        reset_n,
    imm_encode_if.slave bus
);

    enc_state_e  state_r, state_s;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [23:0] instr_r, instr_s;
    logic        encodable_r, encodable_s;
    logic        accept_s;
    imm_fit_t    fit_s;

`ifdef ROT_IMM_EN
    localparam int K_W = (ROT_STEPS > 1) ? $clog2(ROT_STEPS) : 1;
    logic [31:0]    rot_r, rot_s;
    logic [K_W-1:0] k_r, k_s;
`endif

    imm_fit_check u_fit (
        .value   (bus.value),
        .imm_src (bus.ImmSrc),
        .fit     (fit_s)
    );

    assign accept_s      = bus.in_valid && in_ready_r;
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.Instr     = instr_r;
    assign bus.encodable = encodable_r;

    // Next-state and result selection.
    always_comb begin
        state_s     = state_r;
        instr_s     = instr_r;
        encodable_s = encodable_r;
`ifdef ROT_IMM_EN
        rot_s       = rot_r;
        k_s         = k_r;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef ROT_IMM_EN
                    if (imm_src_e'(bus.ImmSrc) == IMM_DP) begin
                        rot_s   = bus.value;
                        k_s     = '0;
                        state_s = SEARCH;
                    end else begin
                        instr_s     = fit_s.instr;
                        encodable_s = fit_s.encodable;
                        state_s     = DONE;
                    end
`else
                    instr_s     = fit_s.instr;
                    encodable_s = fit_s.encodable;
                    state_s     = DONE;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            SEARCH: begin
`ifdef ROT_IMM_EN
                // Smallest rotation wins because k counts upward from zero.
                if (rot_r[31:8] == 24'h000000) begin
                    instr_s     = {12'h000, 4'(k_r), rot_r[7:0]};
                    encodable_s = 1'b1;
                    state_s     = DONE;
                end else if (k_r == K_W'(ROT_STEPS - 1)) begin
                    instr_s     = 24'h000000;
                    encodable_s = 1'b0;
                    state_s     = DONE;
                end else begin
                    rot_s   = rol2(rot_r);
                    k_s     = k_r + K_W'(1);
                    state_s = SEARCH;
                end
`else
                state_s = IDLE;
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, handshake flags and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            instr_r     <= 24'h000000;
            encodable_r <= 1'b0;
`ifdef ROT_IMM_EN
            rot_r       <= 32'h00000000;
            k_r         <= '0;
`endif
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
            instr_r     <= instr_s;
            encodable_r <= encodable_s;
`ifdef ROT_IMM_EN
            rot_r       <= rot_s;
            k_r         <= k_s;
`endif
        end
    end

endmodule
